// File: rtl/udl_counter_ctrl.sv
// rtl/udl_counter_ctrl.sv - push-button front end for the up/down/load counter
//
// Synchronizes and debounces the up/down/load buttons, detects press edges,
// auto-repeats a held up or down button, arbitrates everything into at most
// one registered command per cycle, and captures the load value.
//
// Ports:
//   clk       in   rising-edge system clock
//   reset_n   in   asynchronous active-low reset
//   btn_up    in   raw up button (async, bouncy, active-high)
//   btn_down  in   raw down button (async, bouncy, active-high)
//   btn_load  in   raw load button (async, bouncy, active-high)
//   sw        in   raw load-value switches (async)
//   en        out  one-cycle command strobe
//   up        out  direction, 1 = increment; 0 unless en
//   load      out  load command; 0 unless en
//   D         out  load value, captured on load commands only

module udl_counter_ctrl #(
  parameter int BITS          = 4,
  parameter int DB_CYCLES     = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            btn_load,
  input  logic [BITS-1:0] sw,
  output logic            en,
  output logic            up,
  output logic            load,
  output logic [BITS-1:0] D
);

  localparam int DBW  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  // Button index order in the vectors below: 0 = up, 1 = down, 2 = load.
  localparam int B_UP   = 0;
  localparam int B_DOWN = 1;
  localparam int B_LOAD = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RPT
  } state_t;

  logic [2:0]      btn_s1, btn_s2;
  logic [BITS-1:0] sw_s1, sw_s2;
  logic [2:0]      db, db_q;
  logic [DBW-1:0]  db_cnt [3];

  state_t          state;
  logic [TW-1:0]   tmr;
  logic            dir;   // button owned by HOLD/RPT: 1 = up, 0 = down

  logic [2:0]      press;
  logic            held_btn, other_btn, abort, tmr_hit, rpt;
  logic            cmd_load, cmd_up, cmd_down;

  // Synchronizers and per-button debouncers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
      db     <= '0;
      db_q   <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      btn_s1 <= {btn_load, btn_down, btn_up};
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      db_q   <= db;
      for (int i = 0; i < 3; i++) begin
        if (btn_s2[i] != db[i]) begin
          // The DB_CYCLES-th consecutive disagreeing sample flips the level.
          if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    press     = db & ~db_q;
    held_btn  = dir ? db[B_UP]   : db[B_DOWN];
    other_btn = dir ? db[B_DOWN] : db[B_UP];
    abort     = (state != S_IDLE) && (!held_btn || other_btn || db[B_LOAD]);
    tmr_hit   = ((state == S_HOLD) && (tmr == TW'(HOLD_CYCLES - 1))) ||
                ((state == S_RPT)  && (tmr == TW'(REPEAT_CYCLES - 1)));
    rpt       = (state != S_IDLE) && !abort && tmr_hit;
    // Fixed priority: load > up > down; losers are simply dropped.
    cmd_load  = press[B_LOAD];
    cmd_up    = !cmd_load && (press[B_UP] || (rpt && dir));
    cmd_down  = !cmd_load && !cmd_up && (press[B_DOWN] || (rpt && !dir));
  end

  // Auto-repeat FSM and registered command outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      tmr   <= '0;
      dir   <= 1'b0;
      en    <= 1'b0;
      up    <= 1'b0;
      load  <= 1'b0;
      D     <= '0;
    end else begin
      en   <= cmd_load || cmd_up || cmd_down;
      up   <= cmd_up;
      load <= cmd_load;
      if (cmd_load) D <= sw_s2;

      case (state)
        S_IDLE: begin
          tmr <= '0;
          // Repeat only arms when a single direction is held and load is not.
          if (press[B_UP] && !db[B_DOWN] && !db[B_LOAD]) begin
            state <= S_HOLD;
            dir   <= 1'b1;
          end else if (press[B_DOWN] && !db[B_UP] && !db[B_LOAD]) begin
            state <= S_HOLD;
            dir   <= 1'b0;
          end
        end
        S_HOLD, S_RPT: begin
          if (abort) begin
            state <= S_IDLE;
            tmr   <= '0;
          end else if (tmr_hit) begin
            state <= S_RPT;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tmr   <= '0;
        end
      endcase
    end
  end

endmodule
